stream_demux: RTL and testbench

- Parameterised 1-to-N streaming demultiplexer with valid/ready handshakes on the input and on every output.
- Routes whole packets, delimited by a last flag, from one input stream to the output channel selected on the packet's first beat.
- Each output has a one-entry registered slice, so there are no combinational paths from input to output data/valid.
- Sits between a packet source and N independent consumers; it is the clocked, flow-controlled successor to the combinational 1-to-2^n demux.

---
 rtl/stream_demux_pkg.sv | 16 +
 rtl/stream_demux_slice.sv | 50 +++++
 rtl/stream_demux.sv | 125 ++++++++++++
 tb/tb_stream_demux.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/stream_demux_pkg.sv
// stream_demux_pkg: shared types and helpers for the streaming demultiplexer.
//   state_t   - packet FSM state (IDLE / ROUTE / DROP)
//   sel_width - width of the channel select for a given channel count, minimum 1
package stream_demux_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUTE = 2'd1,
    DROP  = 2'd2
  } state_t;

  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_demux_slice.sv
// demux_slice: one-entry registered slice (W data bits + last) with valid/ready.
// Ports:
//   clk, rstN    - clock, asynchronous active-low reset
//   load         - accept inData/inLast this cycle (only asserted when the
//                  slice is empty or being drained in the same cycle)
//   inData       - beat data to register
//   inLast       - beat last flag to register
//   ready        - downstream ready
//   valid        - slice holds a beat
//   data, last   - registered beat, held stable while valid && !ready
module demux_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstN,
  input  logic         load,
  input  logic [W-1:0] inData,
  input  logic         inLast,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         last
);

  logic [W-1:0] data_p1;
  logic         last_p1;
  logic         vld_p1;

  // ---- stage p1: registered beat ----
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      last_p1 <= 1'b0;
    end else if (load) begin
      // A load during a drain simply replaces the departing beat.
      vld_p1  <= 1'b1;
      data_p1 <= inData;
      last_p1 <= inLast;
    end else if (ready) begin
      // Drain clears valid only; data is left as-is.
      vld_p1  <= 1'b0;
    end
  end

  assign valid = vld_p1;
  assign data  = data_p1;
  assign last  = last_p1;

endmodule

// File: rtl/stream_demux.sv
// stream_demux: clocked 1-to-N packet demultiplexer with valid/ready on the
// input and on every output channel.
// The channel is chosen by inSel on the first beat of each packet; the rest of
// the packet follows that channel regardless of inSel. Packets whose select is
// out of range are accepted and discarded, counted in dropCount (saturating)
// and flagged by the sticky selErr.
// Ports:
//   clk, rstN          - clock, asynchronous active-low reset
//   inData/inSel/inLast/inValid/inReady - input stream
//   outData            - N*W flattened bus, channel k at [k*W +: W]
//   outLast/outValid/outReady - per-channel stream control
//   dropCount          - saturating count of discarded beats
//   selErr             - sticky out-of-range select flag
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int W  = 8,
  localparam int SW = sel_width(N),
  parameter  int CW = 8
) (
  input  logic            clk,
  input  logic            rstN,
  input  logic [W-1:0]    inData,
  input  logic [SW-1:0]   inSel,
  input  logic            inLast,
  input  logic            inValid,
  output logic            inReady,
  output logic [N*W-1:0]  outData,
  output logic [N-1:0]    outLast,
  output logic [N-1:0]    outValid,
  input  logic [N-1:0]    outReady,
  output logic [CW-1:0]   dropCount,
  output logic            selErr
);

  state_t        state, state_nxt;
  logic [SW-1:0] cur;
  logic [SW-1:0] tgt;
  logic          sel_ok;
  logic          tgt_free;
  logic          accept;
  logic          route;
  logic          drop;
  logic [N-1:0]  load;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  // Select decode, ready mux and next-state logic.
  always_comb begin
    sel_ok    = 1'b0;
    tgt       = (state == IDLE) ? inSel : cur;
    tgt_free  = 1'b1;
    inReady   = 1'b1;
    accept    = 1'b0;
    route     = 1'b0;
    drop      = 1'b0;
    load      = '0;
    state_nxt = state;

    // Out-of-range selects match no channel, so they leave tgt_free at 1
    // and the beat is accepted for discarding.
    for (int k = 0; k < N; k++) begin
      if (SW'(k) == inSel) sel_ok = 1'b1;
      if (SW'(k) == tgt)   tgt_free = !outValid[k] || outReady[k];
    end

    if (state != DROP) inReady = tgt_free;

    accept = inValid && inReady;
    route  = accept && ((state == ROUTE) || ((state == IDLE) && sel_ok));
    drop   = accept && !route;

    for (int k = 0; k < N; k++) begin
      if (route && (SW'(k) == tgt)) load[k] = 1'b1;
    end

    unique case (state)
      IDLE: begin
        if (accept && !inLast) state_nxt = sel_ok ? ROUTE : DROP;
      end
      ROUTE, DROP: begin
        if (accept && inLast) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- stage p0: FSM, locked channel, drop bookkeeping ----
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state     <= IDLE;
      cur       <= '0;
      dropCount <= '0;
      selErr    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (route && (state == IDLE)) cur <= inSel;
      if (drop) begin
        dropCount <= sat_inc(dropCount);
        selErr    <= 1'b1;
      end
    end
  end

  // ---- stage p1: per-channel output slices ----
  for (genvar k = 0; k < N; k++) begin : g_slice
    demux_slice #(
      .W(W)
    ) u_slice (
      .clk    (clk),
      .rstN   (rstN),
      .load   (load[k]),
      .inData (inData),
      .inLast (inLast),
      .ready  (outReady[k]),
      .valid  (outValid[k]),
      .data   (outData[k*W +: W]),
      .last   (outLast[k])
    );
  end

endmodule

// File: tb/tb_stream_demux.sv
// Directed bench for stream_demux: a 4-channel instance for routing,
// locking, backpressure and mid-packet reset, and a 3-channel instance for
// out-of-range dropping and counter saturation.
module tb_stream_demux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstN;

  logic [7:0]  d4;
  logic [1:0]  s4;
  logic        l4, v4, r4;
  logic [31:0] od4;
  logic [3:0]  ol4, ov4, or4;
  logic [7:0]  dc4;
  logic        se4;

  logic [7:0]  d3;
  logic [1:0]  s3;
  logic        l3, v3, r3;
  logic [23:0] od3;
  logic [2:0]  ol3, ov3, or3;
  logic [7:0]  dc3;
  logic        se3;

  int n_cmp = 0;
  int n_bad = 0;

  stream_demux #(.N(4), .W(8), .CW(8)) dut4 (
    .clk(clk), .rstN(rstN),
    .inData(d4), .inSel(s4), .inLast(l4), .inValid(v4), .inReady(r4),
    .outData(od4), .outLast(ol4), .outValid(ov4), .outReady(or4),
    .dropCount(dc4), .selErr(se4)
  );

  stream_demux #(.N(3), .W(8), .CW(8)) dut3 (
    .clk(clk), .rstN(rstN),
    .inData(d3), .inSel(s3), .inLast(l3), .inValid(v3), .inReady(r3),
    .outData(od3), .outLast(ol3), .outValid(ov3), .outReady(or3),
    .dropCount(dc3), .selErr(se3)
  );

  typedef struct {
    logic        v;
    logic [1:0]  sel;
    logic [7:0]  data;
    logic        last;
    logic [3:0]  ordy;
    logic        xirdy;   // inReady before the edge
    logic [3:0]  xov;     // outValid after the edge
    logic [3:0]  xol;     // outLast after the edge
    logic [31:0] xod;     // outData after the edge
  } vec_t;

  vec_t vt [11];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", nm, got, exp);
    end
  endtask

  initial begin
    // single beat to channel 2
    vt[0]  = '{1'b1, 2'd2, 8'hA5, 1'b1, 4'b1111, 1'b1, 4'b0100, 4'b0100, 32'h00A5_0000};
    vt[1]  = '{1'b0, 2'd0, 8'h00, 1'b0, 4'b1111, 1'b1, 4'b0000, 4'b0100, 32'h00A5_0000};
    // locked packet to channel 1, inSel changes to 3 mid-packet
    vt[2]  = '{1'b1, 2'd1, 8'h11, 1'b0, 4'b1111, 1'b1, 4'b0010, 4'b0100, 32'h00A5_1100};
    vt[3]  = '{1'b1, 2'd3, 8'h22, 1'b0, 4'b1111, 1'b1, 4'b0010, 4'b0100, 32'h00A5_2200};
    vt[4]  = '{1'b1, 2'd3, 8'h33, 1'b1, 4'b1111, 1'b1, 4'b0010, 4'b0110, 32'h00A5_3300};
    vt[5]  = '{1'b0, 2'd0, 8'h00, 1'b0, 4'b1111, 1'b1, 4'b0000, 4'b0110, 32'h00A5_3300};
    // backpressure on channel 1 while channel 0 holds then drains
    vt[6]  = '{1'b1, 2'd0, 8'h44, 1'b1, 4'b1100, 1'b1, 4'b0001, 4'b0111, 32'h00A5_3344};
    vt[7]  = '{1'b1, 2'd1, 8'h55, 1'b0, 4'b1100, 1'b1, 4'b0011, 4'b0101, 32'h00A5_5544};
    vt[8]  = '{1'b1, 2'd1, 8'h66, 1'b1, 4'b1101, 1'b0, 4'b0010, 4'b0101, 32'h00A5_5544};
    vt[9]  = '{1'b1, 2'd1, 8'h66, 1'b1, 4'b1111, 1'b1, 4'b0010, 4'b0111, 32'h00A5_6644};
    vt[10] = '{1'b0, 2'd0, 8'h00, 1'b0, 4'b1111, 1'b1, 4'b0000, 4'b0111, 32'h00A5_6644};

    rstN = 1'b0;
    d4 = '0; s4 = '0; l4 = 1'b0; v4 = 1'b0; or4 = 4'hF;
    d3 = '0; s3 = '0; l3 = 1'b0; v3 = 1'b0; or3 = 3'h7;

    // Reset held while inputs toggle randomly.
    repeat (5) begin
      @(posedge clk); #1;
      d4 = 8'($urandom); s4 = 2'($urandom); l4 = 1'($urandom); v4 = 1'($urandom);
      or4 = 4'($urandom);
      d3 = 8'($urandom); s3 = 2'($urandom); l3 = 1'($urandom); v3 = 1'($urandom);
      or3 = 3'($urandom);
    end
    #2;
    check("rst_ov4", 32'(ov4), 32'h0);
    check("rst_od4", od4, 32'h0);
    check("rst_dc4", 32'(dc4), 32'h0);
    check("rst_se4", 32'(se4), 32'h0);
    check("rst_ov3", 32'(ov3), 32'h0);
    check("rst_od3", 32'(od3), 32'h0);
    check("rst_dc3", 32'(dc3), 32'h0);
    check("rst_se3", 32'(se3), 32'h0);

    @(posedge clk); #1;
    d4 = '0; s4 = '0; l4 = 1'b0; v4 = 1'b0; or4 = 4'hF;
    d3 = '0; s3 = '0; l3 = 1'b0; v3 = 1'b0; or3 = 3'h7;
    rstN = 1'b1;
    @(posedge clk); #1;
    check("idle_rdy4", 32'(r4), 32'h1);
    check("idle_rdy3", 32'(r3), 32'h1);

    // Table-driven routing, locking and backpressure.
    for (int i = 0; i < 11; i++) begin
      v4 = vt[i].v; s4 = vt[i].sel; d4 = vt[i].data; l4 = vt[i].last; or4 = vt[i].ordy;
      #4;
      check($sformatf("v%0d_irdy", i), 32'(r4), 32'(vt[i].xirdy));
      @(posedge clk); #1;
      check($sformatf("v%0d_ov", i), 32'(ov4), 32'(vt[i].xov));
      check($sformatf("v%0d_ol", i), 32'(ol4), 32'(vt[i].xol));
      check($sformatf("v%0d_od", i), od4, vt[i].xod);
    end
    v4 = 1'b0; s4 = '0; l4 = 1'b0; or4 = 4'hF;

    // Out-of-range packet on the 3-channel instance.
    for (int b = 0; b < 4; b++) begin
      s3 = (b == 0) ? 2'd3 : 2'($urandom);
      d3 = 8'(b + 1); l3 = (b == 3); v3 = 1'b1;
      #4;
      check($sformatf("oor_rdy%0d", b), 32'(r3), 32'h1);
      @(posedge clk); #1;
      check($sformatf("oor_ov%0d", b), 32'(ov3), 32'h0);
    end
    check("oor_dc4", 32'(dc3), 32'd4);
    check("oor_se", 32'(se3), 32'h1);
    for (int i = 0; i < 300; i++) begin
      s3 = 2'd3; l3 = 1'b1; v3 = 1'b1; d3 = 8'(i);
      @(posedge clk); #1;
      if (i == 249) check("sat_dc254", 32'(dc3), 32'd254);
      if (i == 250) check("sat_dc255", 32'(dc3), 32'd255);
    end
    v3 = 1'b0; l3 = 1'b0; s3 = '0;
    check("sat_dc_hold", 32'(dc3), 32'd255);
    check("sat_ov", 32'(ov3), 32'h0);
    check("sat_se", 32'(se3), 32'h1);

    // Mid-packet reset on the 4-channel instance.
    s4 = 2'd0; d4 = 8'h81; l4 = 1'b0; v4 = 1'b1; or4 = 4'hF;
    @(posedge clk); #1;
    d4 = 8'h82; s4 = 2'd2;
    @(posedge clk); #1;
    check("mpr_pre_ov", 32'(ov4), 32'h1);
    check("mpr_pre_od", od4, 32'h00A5_6682);
    v4 = 1'b0;
    rstN = 1'b0;
    #1;
    check("mpr_ov", 32'(ov4), 32'h0);
    check("mpr_od", od4, 32'h0);
    #2;
    rstN = 1'b1;
    s4 = 2'd3; d4 = 8'h77; l4 = 1'b1; v4 = 1'b1;
    #1;
    check("mpr_rdy", 32'(r4), 32'h1);
    @(posedge clk); #1;
    v4 = 1'b0; l4 = 1'b0; s4 = '0;
    check("mpr_new_ov", 32'(ov4), 32'h8);
    check("mpr_new_od", od4, 32'h7700_0000);
    check("mpr_new_ol", 32'(ol4), 32'h8);
    @(posedge clk); #1;
    check("mpr_drain_ov", 32'(ov4), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
